// File: rtl/reg_bank_writer_pkg.sv
// Shared definitions for the register-bank write side: bank geometry and
// the write/clear controller state encoding.
package reg_bank_writer_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_writer_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when en is low.
module dec3to8
    import reg_bank_writer_pkg::*;
(
    input  logic             en,
    input  logic [AW-1:0]    sel,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the 8-entry register file: handshaked single-word writes
// plus a self-timed sweep that zeroes one entry per cycle.
module reg_bank_writer
    import reg_bank_writer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   wr_valid,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [DEPTH*WIDTH-1:0] Q,
    output logic [DEPTH-1:0]       valid
);

    // Valid/ready: a write is taken at a rising edge where wr_valid and
    // wr_ready are both high; the producer holds addr/data until then.
    state_t                        state_q, state_d;
    logic [AW-1:0]                 ptr_q, ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
    logic [DEPTH-1:0]              valid_q, valid_d;

    logic                          wr_fire;
    logic [DEPTH-1:0]              wr_sel;
    logic [DEPTH-1:0]              clr_sel;

    assign wr_ready = (state_q == ST_IDLE) && !clr_req;
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = (state_q == ST_CLEAR);
    assign Q        = mem_q;
    assign valid    = valid_q;

    dec3to8 u_wr_dec (
        .en     (wr_fire),
        .sel    (wr_addr),
        .onehot (wr_sel)
    );

    dec3to8 u_clr_dec (
        .en     (state_q == ST_CLEAR),
        .sel    (ptr_q),
        .onehot (clr_sel)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
                valid_d = valid_q | wr_sel;
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_sel[i]) begin
                        mem_d[i] = wr_data;
                    end
                end
            end
            ST_CLEAR: begin
                valid_d = valid_q & ~clr_sel;
                for (int i = 0; i < DEPTH; i++) begin
                    if (clr_sel[i]) begin
                        mem_d[i] = '0;
                    end
                end
                // Last entry swept: leave with ptr parked at 0 for the next clear.
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mem_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

endmodule
